// File: rtl/mem_slave.sv
// mem_slave: single-port memory slave with LATENCY wait states on the req/ready bus.
// Define MEM_WPROT_EN to reject writes below ROM_TOP (err pulses with mem_ready).
module mem_slave #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LATENCY = 0,
    parameter logic [ADDR_W-1:0] ROM_TOP = 'h10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, nxt;
    logic [3:0]        cnt, cnt_d;
    logic [ADDR_W-1:0] addr_q, cur_addr;
    logic              we_q, cur_we;
    logic [DATA_W-1:0] wdata_q, cur_wdata;
    logic              fire, prot, wr_en;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_comb begin
        nxt = state;
        cnt_d = cnt;
        case (state)
            IDLE: if (mem_req) begin
                cnt_d = 4'(LATENCY);
                nxt = LATENCY > 0 ? WAIT : DONE;
            end
            WAIT: begin
                cnt_d = cnt - 4'd1;
                nxt = cnt == 4'd1 ? DONE : WAIT;
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // With zero latency DONE is entered from IDLE, before the captured copies exist
        cur_addr = state == IDLE ? addr : addr_q;
        cur_we = state == IDLE ? we : we_q;
        cur_wdata = state == IDLE ? wdata : wdata_q;
        fire = nxt == DONE && state != DONE;
    end

`ifdef MEM_WPROT_EN
    assign prot = cur_addr < ROM_TOP;
    assign err = state == DONE && we_q && addr_q < ROM_TOP;
`else
    logic unused_rom;
    assign unused_rom = ^ROM_TOP;
    assign prot = 1'b0;
    assign err = 1'b0;
`endif

    assign wr_en = fire && cur_we && !prot;
    assign mem_ready = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 4'd0;
            rdata <= '0;
            addr_q <= '0;
            we_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= nxt;
            cnt <= cnt_d;
            if (state == IDLE && mem_req) begin
                addr_q <= addr;
                we_q <= we;
                wdata_q <= wdata;
            end
            if (fire && !cur_we) rdata <= mem[cur_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[cur_addr] <= cur_wdata;
    end
endmodule

// File: tb/tb_mem_slave.sv
// tb_mem_slave: directed checks of mem_slave at several latencies and widths.
module tb_mem_slave;
    logic clk = 1'b0;
    logic [3:0] rst = 4'hF, req = 4'h0, we = 4'h0, rdy, er;
    logic [7:0] ad8 [3], wd8 [3], rd8 [3];
    logic [9:0] ad10 = '0;
    logic [15:0] wd16 = '0, rd16;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_slave #(.LATENCY(0)) u_l0 (.clk(clk), .rst(rst[0]), .mem_req(req[0]), .we(we[0]), .addr(ad8[0]),
        .wdata(wd8[0]), .rdata(rd8[0]), .mem_ready(rdy[0]), .err(er[0]));
    mem_slave #(.LATENCY(1)) u_l1 (.clk(clk), .rst(rst[1]), .mem_req(req[1]), .we(we[1]), .addr(ad8[1]),
        .wdata(wd8[1]), .rdata(rd8[1]), .mem_ready(rdy[1]), .err(er[1]));
    mem_slave #(.LATENCY(5)) u_l5 (.clk(clk), .rst(rst[2]), .mem_req(req[2]), .we(we[2]), .addr(ad8[2]),
        .wdata(wd8[2]), .rdata(rd8[2]), .mem_ready(rdy[2]), .err(er[2]));
    mem_slave #(.DATA_W(16), .ADDR_W(10), .LATENCY(3)) u_w16 (.clk(clk), .rst(rst[3]), .mem_req(req[3]),
        .we(we[3]), .addr(ad10), .wdata(wd16), .rdata(rd16), .mem_ready(rdy[3]), .err(er[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input int i);
        if (i == 3) return {16'h0, rd16};
        return {24'h0, rd8[i]};
    endfunction

    task automatic drv(input int i, input logic [15:0] a, input logic [15:0] d);
        if (i == 3) begin
            ad10 = a[9:0];
            wd16 = d;
        end else begin
            ad8[i] = a[7:0];
            wd8[i] = d[7:0];
        end
    endtask

    // One transaction; lat counts edges from the sampling edge to the first edge showing mem_ready
    task automatic xact(input int i, input bit w, input logic [15:0] a, input logic [15:0] d,
                        input int lat, input bit e, input string tag);
        int n;
        logic [31:0] rd0;
        @(negedge clk);
        req[i] = 1'b1;
        we[i] = w;
        drv(i, a, d);
        rd0 = rd_of(i);
        @(posedge clk);
        #1;
        req[i] = 1'b0;
        we[i] = ~w;
        drv(i, ~a, ~d);
        n = 1;
        while (!rdy[i] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_err"}, {31'b0, er[i]}, {31'b0, e});
        if (w) chk({tag, "_rd_hold"}, rd_of(i), rd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'b0, rdy[i]}, 32'h0);
    endtask

    initial begin
        int seen, pulses, consec, bad;
        logic prev;
        for (int i = 0; i < 3; i++) begin
            ad8[i] = '0;
            wd8[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, rdy[0]}, 32'h0);
        chk("rst_err", {31'b0, er[0]}, 32'h0);
        chk("rst_rdata8", rd_of(0), 32'h0);
        chk("rst_rdata16", rd_of(3), 32'h0);
        @(negedge clk);
        rst = 4'h0;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            seen += int'(rdy[0] | er[0]);
        end
        chk("idle_quiet", 32'(seen), 32'h0);

        xact(0, 1'b1, 16'hE0, 16'hA5, 1, 1'b0, "w_e0");
        xact(0, 1'b0, 16'hE0, 16'h00, 1, 1'b0, "r_e0");
        chk("r_e0_data", rd_of(0), 32'hA5);
        xact(0, 1'b1, 16'hE1, 16'h3C, 1, 1'b0, "w_e1");
        xact(0, 1'b0, 16'hE1, 16'h00, 1, 1'b0, "r_e1");
        chk("r_e1_data", rd_of(0), 32'h3C);
        xact(0, 1'b0, 16'hE0, 16'h00, 1, 1'b0, "r_e0b");
        chk("r_e0b_data", rd_of(0), 32'hA5);

        xact(3, 1'b1, 16'h3FF, 16'hBEEF, 4, 1'b0, "w_3ff");
        xact(3, 1'b1, 16'h000, 16'h1234, 4, 1'b0, "w_000");
        xact(3, 1'b0, 16'h3FF, 16'h0000, 4, 1'b0, "r_3ff");
        chk("r_3ff_data", rd_of(3), 32'hBEEF);
        xact(3, 1'b0, 16'h000, 16'h0000, 4, 1'b0, "r_000");
        chk("r_000_data", rd_of(3), 32'h1234);

        xact(1, 1'b1, 16'h01, 16'h5A, 2, 1'b0, "w_01");
        @(negedge clk);
        req[1] = 1'b1;
        we[1] = 1'b0;
        ad8[1] = 8'h01;
        pulses = 0;
        consec = 0;
        bad = 0;
        prev = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (rdy[1]) begin
                pulses++;
                if (prev) consec++;
                if (k % 3 != 2) bad++;
            end
            prev = rdy[1];
        end
        req[1] = 1'b0;
        chk("held_pulses", 32'(pulses), 32'd4);
        chk("held_consec", 32'(consec), 32'd0);
        chk("held_phase", 32'(bad), 32'd0);
        chk("held_data", rd_of(1), 32'h5A);
        repeat (2) @(posedge clk);

        xact(2, 1'b1, 16'h20, 16'h11, 6, 1'b0, "w_20_pre");
        @(negedge clk);
        req[2] = 1'b1;
        we[2] = 1'b1;
        drv(2, 16'h20, 16'h77);
        @(posedge clk);
        #1;
        req[2] = 1'b0;
        seen = 0;
        @(posedge clk);
        #1;
        seen += int'(rdy[2]);
        rst[2] = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            seen += int'(rdy[2]);
        end
        rst[2] = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen += int'(rdy[2]);
        end
        chk("rst_abort_ready", 32'(seen), 32'h0);
        chk("rst_abort_rdata", rd_of(2), 32'h0);
        xact(2, 1'b0, 16'h20, 16'h00, 6, 1'b0, "r_20");
        chk("r_20_data", rd_of(2), 32'h11);

`ifdef MEM_WPROT_EN
        xact(0, 1'b1, 16'h05, 16'h55, 1, 1'b1, "w_rom");
        xact(0, 1'b0, 16'h05, 16'h00, 1, 1'b0, "r_rom");
        chk("r_rom_data", rd_of(0), 32'h000000xx);
`else
        xact(0, 1'b1, 16'h05, 16'h33, 1, 1'b0, "w_05a");
        xact(0, 1'b1, 16'h05, 16'h55, 1, 1'b0, "w_05b");
        xact(0, 1'b0, 16'h05, 16'h00, 1, 1'b0, "r_05");
        chk("r_05_data", rd_of(0), 32'h55);
`endif
        xact(0, 1'b1, 16'h10, 16'h55, 1, 1'b0, "w_10");
        xact(0, 1'b0, 16'h10, 16'h00, 1, 1'b0, "r_10");
        chk("r_10_data", rd_of(0), 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_slave.md
# mem_slave

Parametrised, synthesizable single-port memory slave for the eightbit core's memory bus: it answers `mem_req`/`mem_ready` handshakes with a programmable number of wait states. It replaces ad-hoc bench memory loops as the memory behind the core, in simulation and on target, and is generalised in data width, address width and latency. Optionally, a low address region can be write-protected to act as ROM.

## Interface

- `DATA_W`, 8, data word width in bits
- `ADDR_W`, 8, address width; depth is 2^ADDR_W words
- `LATENCY`, 0, wait cycles inserted before `mem_ready` (0..15)
- `ROM_TOP`, 8'h10, first writable address; used only with `MEM_WPROT_EN`
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `mem_req`  in  1  master request; level, sampled in IDLE
- `we`  in  1  1 = write, 0 = read; sampled with `mem_req`
- `addr`  in  ADDR_W  word address; sampled with `mem_req`
- `wdata`  in  DATA_W  write data; sampled with `mem_req`
- `rdata`  out  DATA_W  registered read data
- `mem_ready`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle pulse, coincident with `mem_ready`, on a rejected write

## Operation

- States:
  - IDLE: waits for a request.
  - WAIT: counts down `LATENCY` cycles.
  - DONE: one cycle, asserts `mem_ready`.
- IDLE with `mem_req`=1 at an edge:
  - `addr`, `we` and `wdata` are captured into internal registers.
  - The wait counter loads `LATENCY`.
  - Next state is WAIT if `LATENCY`>0, else DONE.
- WAIT: the counter decrements each cycle. Moving to DONE on the edge where the counter equals 1.
- Entering DONE:
  - Reads: `mem[addr_q]` is registered into `rdata`.
  - Writes: `wdata_q` is committed to `mem[addr_q]`.
  - `mem_ready`=1 for the DONE cycle only.
- DONE then always returns to IDLE. A `mem_req` still high during DONE is ignored, and it is sampled again in IDLE on the following edge.
- `rdata` holds its value until the next read completes. Writes never change `rdata`.
- Inputs changing during WAIT/DONE have no effect; the captured copies are used.
- Address arithmetic: `addr` is exactly ADDR_W bits, so there is no out-of-range case and no wrap logic.
- Memory contents are not reset and power up as X.

## Timing

- Request sampled at edge k:
  - `mem_ready` is high in cycle k+1+`LATENCY`, i.e. from edge k+1+`LATENCY` to the next edge.
  - `LATENCY`=0 gives a one-cycle response.
- Write data is visible to a read request issued in the cycle after `mem_ready`.
- Back-to-back throughput is one transaction per `LATENCY`+2 cycles.
- Reset values: state IDLE, `mem_ready`=0, `err`=0, `rdata`=0, counter 0.
- Reset mid-transaction:
  - A pending read or write is aborted; memory is not modified.
  - No `mem_ready` pulse is produced.
  - `rst` has priority over every other event on the same edge.

## Configuration

- `MEM_WPROT_EN` defined:
  - A write whose captured address is < `ROM_TOP` is discarded.
  - The transaction still completes: `mem_ready` pulses and `err` pulses in the same cycle.
  - Reads of the region behave normally.
- `MEM_WPROT_EN` undefined:
  - All addresses are writable.
  - `err` is tied to 0.
  - `ROM_TOP` is ignored.

## Test plan

- Reset then idle, `LATENCY`=0: hold `rst` 2 cycles -> `mem_ready`=0, `err`=0, `rdata`=8'h00. No activity for 10 cycles with `mem_req`=0.
- Write/read, `LATENCY`=0: write 8'hA5 to 8'hE0, then read 8'hE0 -> each `mem_ready` pulses 1 cycle after the request edge, and the read returns `rdata`=8'hA5.
- `LATENCY`=3, `DATA_W`=16, `ADDR_W`=10:
  - Stimulus: write 16'hBEEF to 10'h3FF, then read it back.
  - Response: `mem_ready` exactly 4 cycles after each request edge; `rdata`=16'hBEEF.
  - Response: `rdata` is unchanged during the write.
- Held request, `LATENCY`=1: keep `mem_req`=1 reading 8'h01 continuously -> `mem_ready` pulses every 3 cycles; never two consecutive high cycles.
- Reset mid-wait, `LATENCY`=5: write 8'h77 to 8'h20, then assert `rst` 2 cycles after the request -> no `mem_ready`; a following read of 8'h20 returns the prior contents, not 8'h77.
- `MEM_WPROT_EN` with `ROM_TOP`=8'h10:
  - Write 8'h55 to 8'h05 -> `mem_ready` and `err` pulse together; a readback returns the old value.
  - Write 8'h55 to 8'h10 -> succeeds with `err`=0.
